// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the I/D cache to main-memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 28;
    localparam int LINE_W = 128;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
    typedef enum logic       {REQ_I, REQ_D}     req_id_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: on a tie, the requester that was not granted last wins.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic    req_i,
    input  logic    req_d,
    input  req_id_t last_grant,
    output logic    grant_valid,
    output req_id_t grant_id
);

    always_comb begin
        grant_valid = req_i | req_d;
        grant_id    = REQ_I;
        if (req_i && req_d) begin
            grant_id = (last_grant == REQ_I) ? REQ_D : REQ_I;
        end else if (req_d) begin
            grant_id = REQ_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serializes I-cache fills and D-cache fills/writebacks onto one line-wide memory port
// and routes each completion back to the cache that asked for it.
//
// state | meaning
// IDLE  | no transaction; sample requests and grant one
// BUSY  | memory transaction outstanding, request frozen
// RESP  | one-cycle cooldown while the served requester drops its level
module mem_arbiter #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int LINE_W = mem_arb_pkg::LINE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reqI_mem,
    input  logic [ADDR_W-1:0] reqAddrI_mem,
    output logic [LINE_W-1:0] data_to_icache,
    output logic              read_ready_to_icache,
    input  logic              reqD_mem,
    input  logic              reqD_cache_write,
    input  logic [ADDR_W-1:0] reqAddrD_mem,
    input  logic [LINE_W-1:0] data_to_mem_d,
    output logic [LINE_W-1:0] data_to_dcache,
    output logic              read_ready_to_dcache,
    output logic              written_data_ack_to_dcache,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    import mem_arb_pkg::*;

    arb_state_t        state_q,      state_d;
    req_id_t           last_grant_q, last_grant_d;
    req_id_t           cur_id_q,     cur_id_d;
    logic              mem_req_q,    mem_req_d;
    logic              mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q,  mem_wdata_d;
    logic [LINE_W-1:0] data_i_q,     data_i_d;
    logic [LINE_W-1:0] data_d_q,     data_d_d;
    logic              rdy_i_q,      rdy_i_d;
    logic              rdy_d_q,      rdy_d_d;
    logic              wr_ack_q,     wr_ack_d;

    logic    grant_valid;
    req_id_t grant_id;

    mem_arb_rr u_rr (
        .req_i       (reqI_mem),
        .req_d       (reqD_mem),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cur_id_d     = cur_id_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        data_i_d     = data_i_q;
        data_d_d     = data_d_q;
        rdy_i_d      = 1'b0;
        rdy_d_d      = 1'b0;
        wr_ack_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    cur_id_d     = grant_id;
                    last_grant_d = grant_id;
                    mem_req_d    = 1'b1;
                    state_d      = BUSY;
                    if (grant_id == REQ_D) begin
                        mem_we_d   = reqD_cache_write;
                        mem_addr_d = reqAddrD_mem;
                        if (reqD_cache_write) begin
                            mem_wdata_d = data_to_mem_d;
                        end
                    end else begin
                        mem_we_d   = 1'b0;
                        mem_addr_d = reqAddrI_mem;
                    end
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    if (cur_id_q == REQ_I) begin
                        rdy_i_d  = 1'b1;
                        data_i_d = mem_rdata;
                    end else if (mem_we_q) begin
                        wr_ack_d = 1'b1;
                    end else begin
                        rdy_d_d  = 1'b1;
                        data_d_d = mem_rdata;
                    end
                end
            end
            // The served requester's level is still high here; skip a sample.
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_I;
            cur_id_q     <= REQ_I;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            data_i_q     <= '0;
            data_d_q     <= '0;
            rdy_i_q      <= 1'b0;
            rdy_d_q      <= 1'b0;
            wr_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cur_id_q     <= cur_id_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            data_i_q     <= data_i_d;
            data_d_q     <= data_d_d;
            rdy_i_q      <= rdy_i_d;
            rdy_d_q      <= rdy_d_d;
            wr_ack_q     <= wr_ack_d;
        end
    end

    assign mem_req                    = mem_req_q;
    assign mem_we                     = mem_we_q;
    assign mem_addr                   = mem_addr_q;
    assign mem_wdata                  = mem_wdata_q;
    assign data_to_icache             = data_i_q;
    assign data_to_dcache             = data_d_q;
    assign read_ready_to_icache       = rdy_i_q;
    assign read_ready_to_dcache       = rdy_d_q;
    assign written_data_ack_to_dcache = wr_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-timing reference model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              reqI_mem, reqD_mem, reqD_cache_write;
    logic [ADDR_W-1:0] reqAddrI_mem, reqAddrD_mem, mem_addr;
    logic [LINE_W-1:0] data_to_icache, data_to_dcache, data_to_mem_d, mem_wdata, mem_rdata;
    logic              read_ready_to_icache, read_ready_to_dcache, written_data_ack_to_dcache;
    logic              mem_req, mem_we, mem_ready;

    mem_arbiter dut (
        .clk                        (clk),
        .reset                      (reset),
        .reqI_mem                   (reqI_mem),
        .reqAddrI_mem               (reqAddrI_mem),
        .data_to_icache             (data_to_icache),
        .read_ready_to_icache       (read_ready_to_icache),
        .reqD_mem                   (reqD_mem),
        .reqD_cache_write           (reqD_cache_write),
        .reqAddrD_mem               (reqAddrD_mem),
        .data_to_mem_d              (data_to_mem_d),
        .data_to_dcache             (data_to_dcache),
        .read_ready_to_dcache       (read_ready_to_dcache),
        .written_data_ack_to_dcache (written_data_ack_to_dcache),
        .mem_req                    (mem_req),
        .mem_we                     (mem_we),
        .mem_addr                   (mem_addr),
        .mem_wdata                  (mem_wdata),
        .mem_rdata                  (mem_rdata),
        .mem_ready                  (mem_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: a transaction is granted at the first idle sample edge with a
    // request pending; it completes at the edge memory answers; the next sample edge
    // is two edges later (one cooldown edge in between).
    bit                m_active, m_id_d, m_we, m_last_d, m_rst;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata;
    logic [LINE_W-1:0] e_di = '0, e_dd = '0;
    bit                e_pi, e_pd, e_wa;
    int                edge_n = 0, m_next_sample = 0, lat_left = 0;

    int                fixed_lat = 0, p_new = 0;
    bit                spurious_en = 0, inj_ready = 0, use_fixed = 0;
    logic [LINE_W-1:0] fixed_rdata = '0;
    bit                drop_i = 0, drop_d = 0, prev_req = 0;
    int                obs_grant_edge = 0, obs_done_edge = 0;
    bit                done_log[$];

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_edge();
        e_pi  = 0;
        e_pd  = 0;
        e_wa  = 0;
        m_rst = reset;
        if (reset) begin
            m_active      = 0;
            m_last_d      = 0;
            m_next_sample = edge_n + 1;
            e_di          = '0;
            e_dd          = '0;
        end else if (m_active) begin
            if (mem_ready) begin
                m_active      = 0;
                m_next_sample = edge_n + 2;
                if (!m_id_d) begin
                    e_pi = 1;
                    e_di = mem_rdata;
                end else if (!m_we) begin
                    e_pd = 1;
                    e_dd = mem_rdata;
                end else begin
                    e_wa = 1;
                end
            end
        end else if (edge_n >= m_next_sample && (reqI_mem || reqD_mem)) begin
            m_id_d   = (reqI_mem && reqD_mem) ? !m_last_d : reqD_mem;
            m_last_d = m_id_d;
            m_active = 1;
            m_we     = m_id_d && reqD_cache_write;
            m_addr   = m_id_d ? reqAddrD_mem : reqAddrI_mem;
            m_wdata  = data_to_mem_d;
            lat_left = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
        end
    endtask

    task automatic compare();
        check("mem_req", LINE_W'(mem_req), LINE_W'(m_active));
        if (m_active) begin
            check("mem_we", LINE_W'(mem_we), LINE_W'(m_we));
            check("mem_addr", LINE_W'(mem_addr), LINE_W'(m_addr));
            if (m_we) check("mem_wdata", mem_wdata, m_wdata);
        end
        if (m_rst) begin
            check("rst_mem_we", LINE_W'(mem_we), '0);
            check("rst_mem_addr", LINE_W'(mem_addr), '0);
            check("rst_mem_wdata", mem_wdata, '0);
        end
        check("rdy_i", LINE_W'(read_ready_to_icache), LINE_W'(e_pi));
        check("rdy_d", LINE_W'(read_ready_to_dcache), LINE_W'(e_pd));
        check("wr_ack", LINE_W'(written_data_ack_to_dcache), LINE_W'(e_wa));
        check("data_i", data_to_icache, e_di);
        check("data_d", data_to_dcache, e_dd);
    endtask

    // Requesters hold their level until one cycle after the completion pulse.
    task automatic drive();
        if (drop_i) begin
            reqI_mem = 0;
            drop_i   = 0;
        end else if (e_pi) begin
            drop_i = 1;
        end else if (!reqI_mem && int'($urandom_range(0, 99)) < p_new) begin
            reqI_mem     = 1;
            reqAddrI_mem = ADDR_W'($urandom);
        end
        if (drop_d) begin
            reqD_mem = 0;
            drop_d   = 0;
        end else if (e_pd || e_wa) begin
            drop_d = 1;
        end else if (!reqD_mem && int'($urandom_range(0, 99)) < p_new) begin
            reqD_mem         = 1;
            reqD_cache_write = $urandom_range(0, 1) == 1;
            reqAddrD_mem     = ADDR_W'($urandom);
            data_to_mem_d    = rand_line();
        end
        mem_rdata = use_fixed ? fixed_rdata : rand_line();
        if (m_active) begin
            if (lat_left <= 1) begin
                mem_ready = 1;
                lat_left  = 0;
            end else begin
                lat_left--;
                mem_ready = 0;
            end
        end else begin
            mem_ready = inj_ready || (spurious_en && $urandom_range(0, 7) == 0);
            inj_ready = 0;
        end
    endtask

    task automatic cycle();
        drive();
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
        compare();
        if (mem_req && !prev_req) obs_grant_edge = edge_n;
        prev_req = mem_req;
        if (read_ready_to_icache || read_ready_to_dcache || written_data_ack_to_dcache) begin
            obs_done_edge = edge_n;
            done_log.push_back(!read_ready_to_icache);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until_idle(input string tag);
        int n = 0;
        while ((reqI_mem || reqD_mem || m_active || drop_i || drop_d) && n < 300) begin
            cycle();
            n++;
        end
        check({tag, "_timeout"}, LINE_W'(n >= 300), '0);
    endtask

    initial begin
        reset            = 1;
        reqI_mem         = 0;
        reqD_mem         = 0;
        reqD_cache_write = 0;
        reqAddrI_mem     = '0;
        reqAddrD_mem     = '0;
        data_to_mem_d    = '0;
        mem_rdata        = '0;
        mem_ready        = 0;
        cycles(3);
        reset = 0;

        // I read alone, fixed latency 4
        fixed_lat    = 4;
        use_fixed    = 1;
        fixed_rdata  = {32'hDEADBEEF, 32'h0, 32'h0, 32'h1};
        reqI_mem     = 1;
        reqAddrI_mem = 28'h0000010;
        run_until_idle("i_read");
        check("i_read_latency", LINE_W'(obs_done_edge - obs_grant_edge), LINE_W'(4));
        check("i_read_data", data_to_icache, {32'hDEADBEEF, 32'h0, 32'h0, 32'h1});

        // D writeback
        use_fixed        = 0;
        reqD_mem         = 1;
        reqD_cache_write = 1;
        reqAddrD_mem     = 28'h0000020;
        data_to_mem_d    = {16{8'hA5}};
        run_until_idle("d_wb");
        check("d_wb_no_fill", data_to_dcache, '0);

        // Simultaneous requests after reset, held continuously: D, I, D, I
        reset = 1;
        cycle();
        reset            = 0;
        fixed_lat        = 2;
        reqI_mem         = 1;
        reqAddrI_mem     = 28'h1000000;
        reqD_mem         = 1;
        reqD_cache_write = 0;
        reqAddrD_mem     = 28'hD000000;
        done_log.delete();
        p_new = 100;
        cycles(40);
        p_new = 0;
        run_until_idle("rr");
        check("rr_count", LINE_W'(done_log.size() >= 4), LINE_W'(1));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_order%0d", i), LINE_W'(done_log[i]), LINE_W'(i % 2 == 0));
        end

        // Reset two cycles into BUSY, then a stale mem_ready
        fixed_lat    = 20;
        reqI_mem     = 1;
        reqAddrI_mem = 28'h0ABCDEF;
        for (int n = 0; n < 20 && !m_active; n++) cycle();
        check("t5_granted", LINE_W'(mem_req), LINE_W'(1));
        cycles(2);
        reset    = 1;
        reqI_mem = 0;
        drop_i   = 0;
        cycle();
        reset     = 0;
        inj_ready = 1;
        cycle();
        cycles(3);
        check("t5_idle_req", LINE_W'(mem_req), '0);

        // mem_ready while idle, then a normal D fill
        fixed_lat = 3;
        inj_ready = 1;
        cycle();
        cycles(2);
        reqD_mem         = 1;
        reqD_cache_write = 0;
        reqAddrD_mem     = 28'h0000040;
        run_until_idle("d_fill");
        check("d_fill_latency", LINE_W'(obs_done_edge - obs_grant_edge), LINE_W'(3));

        // Randomized traffic
        fixed_lat   = 0;
        spurious_en = 1;
        p_new       = 30;
        cycles(3000);
        p_new = 0;
        run_until_idle("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
